instr_fetch_unit: RTL

- Front-end fetch stage of the core. Drives the instruction-cache word address and captures the returned instruction word.
- Buffers fetched words with their PCs in a small prefetch queue and presents them to decode with a valid/ready handshake.
- Handles control-flow redirects from execute by flushing the queue and restarting fetch at the target PC.
- Sits directly upstream of decode. instr_cache is a combinational read: data for the address driven in a cycle is valid in that same cycle.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instr_fetch_unit.sv | 75 +++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the queue entry type for the fetch stage.
// Build option FETCH_MISALIGN_EN adds a misaligned flag to each entry.
package fetch_pkg;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
`ifdef FETCH_MISALIGN_EN
        logic        misaligned;
`endif
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular prefetch queue of fetch_entry_t with flush.
// Ports: clk_i/rst_ni (async active-low), push_i/din_i write, pop_i read,
// flush_i empties the queue (a push in the same cycle lands as the sole
// entry), full_o/empty_o status, head_o current head (last head while empty).
// Build option FETCH_MISALIGN_EN only changes the entry width.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t din_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    fetch_entry_t   r_hold;
    logic [AW-1:0]  r_wptr, r_rptr;
    logic [AW:0]    r_count;

    assign full_o  = r_count == (AW+1)'(DEPTH);
    assign empty_o = r_count == '0;
    // While empty, present the last head so decode-side outputs hold.
    assign head_o  = empty_o ? r_hold : r_mem[r_rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_hold  <= '0;
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else begin
            r_hold <= head_o;
            if (flush_i) begin
                r_rptr  <= '0;
                r_wptr  <= push_i ? AW'(1) : '0;
                r_count <= push_i ? (AW+1)'(1) : '0;
                if (push_i) r_mem[0] <= din_i;
            end else begin
                if (push_i) begin
                    r_mem[r_wptr] <= din_i;
                    r_wptr        <= r_wptr + AW'(1);
                end
                if (pop_i) r_rptr <= r_rptr + AW'(1);
                r_count <= r_count + (AW+1)'(push_i) - (AW+1)'(pop_i);
            end
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: front-end fetch stage; drives the icache word address,
// queues {pc, instr} pairs and hands them to decode with valid/ready.
// Ports: clk_i, rst_ni (async active-low); instr_cache_address_o/_data_i
// combinational icache read; redirect_i/redirect_pc_i flush and restart;
// instr_valid_o/instr_o/instr_pc_o/instr_ready_i decode handshake.
// Build option FETCH_MISALIGN_EN adds instr_misaligned_o: a misaligned
// redirect enqueues a flagged NOP and halts fetch until the next redirect.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:2] instr_cache_address_o,
    input  logic [31:0] instr_cache_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
`ifdef FETCH_MISALIGN_EN
    output logic        instr_misaligned_o,
`endif
    input  logic        instr_ready_i
);
    logic [31:0]  r_pc;
    logic         w_pop, w_push, w_full, w_empty;
    fetch_entry_t w_din, w_head;

    assign w_pop = !w_empty && instr_ready_i;

`ifdef FETCH_MISALIGN_EN
    logic r_halt;
    logic w_mis;
    assign w_mis  = redirect_i && |redirect_pc_i[1:0];
    // The flagged NOP rides in with the flush; normal fetch stops while halted.
    assign w_push = w_mis || (!redirect_i && !r_halt && (!w_full || w_pop));
    assign w_din  = w_mis ? '{pc: redirect_pc_i, instr: NOP_INSTR, misaligned: 1'b1}
                          : '{pc: r_pc, instr: instr_cache_data_i, misaligned: 1'b0};
    assign instr_misaligned_o = w_head.misaligned;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_halt <= 1'b0;
        else if (redirect_i) r_halt <= w_mis;
    end
`else
    assign w_push = !redirect_i && (!w_full || w_pop);
    assign w_din  = '{pc: r_pc, instr: instr_cache_data_i};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_pc <= RESET_PC;
        else if (redirect_i) r_pc <= redirect_pc_i & ~32'd3;
        else if (w_push) r_pc <= r_pc + 32'd4;
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (redirect_i),
        .din_i   (w_din),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

    assign instr_cache_address_o = r_pc[31:2];
    assign instr_valid_o         = !w_empty;
    assign instr_o               = w_head.instr;
    assign instr_pc_o            = w_head.pc;
endmodule
